// File: rtl/serial_ripple_subtractor.sv
// Digit-serial subtractor: diff = a - b - bin, W bits per clock, using a + ~b with carry-in ~bin.
// Define SUB_OVERFLOW_EN to add the signed-overflow output ovf.

module FullAdderCell (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_s,
    output logic o_cout
);
    assign o_s    = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

module serial_ripple_subtractor #(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] diff,
    output logic         bo
`ifdef SUB_OVERFLOW_EN
    ,
    output logic         ovf
`endif
);
    localparam int D  = (W >= 1) ? N / W : 1;
    localparam int IW = (D > 1) ? $clog2(D) : 1;

    generate
        if (W < 1 || (N % W) != 0) begin : g_bad_cfg
            $error("serial_ripple_subtractor: N must be a positive multiple of W");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          r_state, w_next;
    logic [N-1:0]    r_a, r_nb, r_diff;
    logic            r_carry, r_bo;
    logic [IW-1:0]   r_idx;
    logic [W:0]      w_c;
    logic [W-1:0]    w_sum;
    logic            w_accept, w_last;

    assign w_c[0] = r_carry;

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_cell
            FullAdderCell u_fa (
                .i_a    (r_a[gi]),
                .i_b    (r_nb[gi]),
                .i_cin  (w_c[gi]),
                .o_s    (w_sum[gi]),
                .o_cout (w_c[gi+1])
            );
        end
    endgenerate

    assign w_accept = (r_state == IDLE) && in_valid;
    assign w_last   = (r_idx == IW'(D - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_next = RUN;
            RUN:     if (w_last) w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_nb    <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_diff  <= '0;
            r_bo    <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_nb    <= ~b;
            r_carry <= ~bin;
            r_idx   <= '0;
        end else if (r_state == RUN) begin
            for (int d = 0; d < D; d++)
                if (r_idx == IW'(d)) r_diff[d*W +: W] <= w_sum;
            r_carry <= w_c[W];
            r_a     <= r_a >> W;
            r_nb    <= r_nb >> W;
            r_idx   <= r_idx + 1'b1;
            if (w_last) r_bo <= ~w_c[W];
        end
    end

`ifdef SUB_OVERFLOW_EN
    logic r_ovf;
    // Signed overflow: carry into the MSB differs from carry out of it on the top digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         r_ovf <= 1'b0;
        else if (r_state == RUN && w_last)  r_ovf <= w_c[W] ^ w_c[W-1];
    end
    assign ovf = r_ovf;
`endif

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign diff      = r_diff;
    assign bo        = r_bo;

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Self-checking bench for serial_ripple_subtractor (N=16, W=4) against an arithmetic model.
`timescale 1ns/1ps
module tb_serial_ripple_subtractor;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [15:0] a = '0, b = '0;
    logic        bin = 1'b0;
    logic        out_valid, out_ready = 1'b0;
    logic [15:0] diff;
    logic        bo;
    logic        ovf_w;
    int          n_cmp = 0, n_bad = 0;

    serial_ripple_subtractor #(.N(16), .W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .bo(bo)
`ifdef SUB_OVERFLOW_EN
        , .ovf(ovf_w)
`endif
    );
`ifndef SUB_OVERFLOW_EN
    assign ovf_w = 1'b0;
`endif

    always #5 clk = ~clk;

    // {ovf, bo, diff} from plain signed/unsigned integer arithmetic
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y, input logic c);
        int ud, sd;
        logic [15:0] d;
        ud = int'(x) - int'(y) - int'(c);
        sd = int'($signed(x)) - int'($signed(y)) - int'(c);
        d  = 16'(ud);
        return {(sd > 32767 || sd < -32768), (ud < 0), d};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // One operation: wait for in_ready, accept, check latency/result, hold for `hold` cycles,
    // optionally presenting a pending operand during the hold, then complete the handshake.
    task automatic do_op(input logic [15:0] x, input logic [15:0] y, input logic c,
                         input int hold, input logic pend, input logic [15:0] px);
        logic [17:0] e;
        int lat, wt;
        e = model(x, y, c);
        wt = 0;
        while (!in_ready && wt < 30) begin tick(); wt++; end
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        in_valid = 1'b1; a = x; b = y; bin = c;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            if (in_ready) begin check("in_ready_busy", 32'(in_ready), 32'd0); end
            tick(); lat++;
        end
        check("latency", 32'(lat), 32'd4);
        check("diff", 32'(diff), 32'(e[15:0]));
        check("bo", 32'(bo), 32'(e[16]));
`ifdef SUB_OVERFLOW_EN
        check("ovf", 32'(ovf_w), 32'(e[17]));
`endif
        if (pend) begin in_valid = 1'b1; a = px; b = 16'h0001; bin = 1'b0; end
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_diff", {15'd0, bo, diff}, {15'd0, e[16], e[15:0]});
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("post_valid", 32'(out_valid), 32'd0);
        check("post_in_ready", 32'(in_ready), 32'd1);
        check("post_diff", {15'd0, bo, diff}, {15'd0, e[16], e[15:0]});
    endtask

    initial begin
        logic [15:0] rx, ry;
        logic        rc;
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_bo", 32'(bo), 32'd0);
        rst_n = 1'b1;
        tick();

        // Reset mid-RUN discards the partial result
        in_valid = 1'b1; a = 16'h1234; b = 16'h0001; bin = 1'b0;
        tick(); in_valid = 1'b0;
        tick(); tick();
        rst_n = 1'b0; #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_diff", 32'(diff), 32'd0);
        check("midrst_bo", 32'(bo), 32'd0);
        tick(); rst_n = 1'b1; tick();
        do_op(16'h0005, 16'h0003, 1'b0, 0, 1'b0, 16'h0);

        do_op(16'h1234, 16'h0234, 1'b0, 1, 1'b0, 16'h0);
        do_op(16'h0000, 16'h0001, 1'b0, 0, 1'b0, 16'h0);
        do_op(16'h0000, 16'h0000, 1'b1, 0, 1'b0, 16'h0);
        do_op(16'h1234, 16'h1234, 1'b0, 0, 1'b0, 16'h0);
        do_op(16'h1000, 16'h0001, 1'b0, 0, 1'b0, 16'h0);
        do_op(16'h8000, 16'h0001, 1'b0, 0, 1'b0, 16'h0);
        do_op(16'h7FFF, 16'hFFFF, 1'b0, 0, 1'b0, 16'h0);

        // Backpressure with a pending operand that must wait for DONE->IDLE
        do_op(16'h4321, 16'h1111, 1'b1, 10, 1'b1, 16'hFFFF);
        check("pend_in_valid_held", 32'(in_valid), 32'd1);
        do_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0, 16'h0);

        for (int k = 0; k < 24; k++) begin
            rx = 16'($urandom); ry = 16'($urandom); rc = 1'($urandom);
            do_op(rx, ry, rc, int'($urandom_range(0, 2)), 1'b0, 16'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
